multicycle_alu: RTL and testbench

Parametrised successor to the single-cycle ALU. Executes the existing logical, arithmetic and compare operations with one-cycle registered latency, and adds iterative unsigned multiply and divide that take WIDTH cycles. A start/busy/done handshake lets the control unit stall while a long operation runs. It sits in the execute stage and is driven by the ALU control decode.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/mul_div_unit.sv | 82 ++++++++
 rtl/multicycle_alu.sv | 122 ++++++++++++
 tb/tb_multicycle_alu.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op codes, FSM states and the
// long-operation predicate.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// accumulator and one operand shift register. hi_val/lo_val show the values
// after the step taken at the coming edge.
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_val,
    output logic [WIDTH-1:0] lo_val,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] opb_r;
    logic             mode_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] acc_s;
    logic [WIDTH-1:0] quo_s;

    // One iteration: multiply adds and shifts right, divide shifts left and
    // keeps the difference when it does not borrow.
    always_comb begin
        mul_sum_s = {1'b0, acc_r} + (quo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        shifted_s = {acc_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, opb_r};
        acc_s     = acc_r;
        quo_s     = quo_r;
        if (mode_r) begin
            if (!diff_s[WIDTH]) begin
                acc_s = diff_s[WIDTH-1:0];
                quo_s = {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_s = shifted_s[WIDTH-1:0];
                quo_s = {quo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_s = mul_sum_s[WIDTH:1];
            quo_s = {mul_sum_s[0], quo_r[WIDTH-1:1]};
        end
    end

    assign hi_val = acc_s;
    assign lo_val = quo_s;
    assign last   = (cnt_r == CW'(WIDTH - 1));

    // Datapath registers: loaded on acceptance, advanced once per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r  <= {WIDTH{1'b0}};
            quo_r  <= {WIDTH{1'b0}};
            opb_r  <= {WIDTH{1'b0}};
            mode_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else if (load) begin
            acc_r  <= {WIDTH{1'b0}};
            quo_r  <= a;
            opb_r  <= b;
            mode_r <= mode;
            cnt_r  <= {CW{1'b0}};
        end else if (step) begin
            acc_r  <= acc_s;
            quo_r  <= quo_s;
            cnt_r  <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logical/arithmetic/compare ops plus iterative
// MULTU/DIVU behind a start/busy/done handshake.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    state_t           state_r;
    state_t           state_s;
    logic             accept_s;
    logic             long_s;
    logic             finish_s;
    logic [WIDTH-1:0] short_res_s;
    logic [WIDTH-1:0] md_hi_s;
    logic [WIDTH-1:0] md_lo_s;
    logic             md_last_s;
    logic             is_div_r;
    logic             b_zero_r;

    assign accept_s = start && (state_r != RUN);
    assign long_s   = is_long_op(op);
    assign finish_s = (state_r == RUN) && md_last_s;

    mul_div_unit #(.WIDTH(WIDTH)) u_mul_div (
        .clk    (clk),
        .reset  (reset),
        .load   (accept_s && long_s),
        .mode   (op == OP_DIVU),
        .step   (state_r == RUN),
        .a      (in1),
        .b      (in2),
        .hi_val (md_hi_s),
        .lo_val (md_lo_s),
        .last   (md_last_s)
    );

    // Short-op results, evaluated on the live operands at acceptance.
    always_comb begin
        short_res_s = {WIDTH{1'b0}};
        case (op)
            OP_AND:  short_res_s = in1 & in2;
            OP_OR:   short_res_s = in1 | in2;
            OP_ADD:  short_res_s = in1 + in2;
            OP_SUB:  short_res_s = in1 - in2;
            OP_SLT:  short_res_s = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLTU: short_res_s = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_NOR:  short_res_s = ~(in1 | in2);
            default: short_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic; DONE accepts a new request exactly like IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = long_s ? RUN : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (md_last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, handshake and result registers; results change only with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= {WIDTH{1'b0}};
            hi          <= {WIDTH{1'b0}};
            zero        <= 1'b1;
            div_by_zero <= 1'b0;
            is_div_r    <= 1'b0;
            b_zero_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == RUN);
            done    <= (state_s == DONE);
            if (accept_s && long_s) begin
                is_div_r <= (op == OP_DIVU);
                b_zero_r <= (in2 == {WIDTH{1'b0}});
            end
            if (accept_s && !long_s) begin
                result      <= short_res_s;
                hi          <= {WIDTH{1'b0}};
                zero        <= (short_res_s == {WIDTH{1'b0}});
                div_by_zero <= 1'b0;
            end else if (finish_s) begin
                result      <= md_lo_s;
                hi          <= md_hi_s;
                zero        <= (md_lo_s == {WIDTH{1'b0}});
                div_by_zero <= is_div_r && b_zero_r;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH = 32.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic [W-1:0]  result;
    logic [W-1:0]  hi;
    logic          zero;
    logic          div_by_zero;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .result      (result),
        .hi          (hi),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        tick();
        start = 1'b0;
        in1   = 32'hDEADBEEF;
        in2   = 32'h0BADF00D;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".result"}, 64'(result), 64'h0);
        check({tag, ".hi"}, 64'(hi), 64'h0);
        check({tag, ".zero"}, 64'(zero), 64'h1);
        check({tag, ".dbz"}, 64'(div_by_zero), 64'h0);
        check({tag, ".busy"}, 64'(busy), 64'h0);
        check({tag, ".done"}, 64'(done), 64'h0);
    endtask

    task automatic do_short(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_res);
        go(o, a, b);
        check({tag, ".done"}, 64'(done), 64'h1);
        check({tag, ".busy"}, 64'(busy), 64'h0);
        check({tag, ".result"}, 64'(result), 64'(exp_res));
        check({tag, ".hi"}, 64'(hi), 64'h0);
        check({tag, ".zero"}, 64'(zero), 64'(exp_res == 32'h0));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'h0);
    endtask

    task automatic do_long(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic noise,
                           input logic [W-1:0] exp_res, input logic [W-1:0] exp_hi,
                           input logic exp_dbz);
        int cyc;
        int bc;
        go(o, a, b);
        cyc = 1;
        bc  = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) begin
                bc++;
                if (noise) begin
                    start = cyc[0];
                    op    = OP_ADD;
                    in1   = 32'(cyc);
                    in2   = 32'h1;
                end
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check({tag, ".done_cycle"}, 64'(cyc), 64'(W + 1));
        check({tag, ".busy_cycles"}, 64'(bc), 64'(W));
        check({tag, ".busy_at_done"}, 64'(busy), 64'h0);
        check({tag, ".result"}, 64'(result), 64'(exp_res));
        check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        check({tag, ".zero"}, 64'(zero), 64'(exp_res == 32'h0));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start = 1'b0;
        op    = 4'h0;
        in1   = 32'h0;
        in2   = 32'h0;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        check("idle.busy", 64'(busy), 64'h0);
        do_short("add", OP_ADD, 32'd5, 32'd5, 32'd10);
        do_short("sub", OP_SUB, 32'd5, 32'd5, 32'd0);
        do_short("slt", OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1);
        do_short("sltu", OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0);
        do_short("and", OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000);
        do_short("or", OP_OR, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0);
        do_short("illegal", 4'b1111, 32'd5, 32'd5, 32'd0);
        do_short("nor", OP_NOR, 32'd0, 32'd0, 32'hFFFFFFFF);

        tick();
        check("hold.done", 64'(done), 64'h0);
        check("hold.result", 64'(result), 64'hFFFFFFFF);

        do_long("mul1", OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 32'hFFFFFFFE, 32'h1, 1'b0);
        do_short("b2b_add", OP_ADD, 32'd3, 32'd4, 32'd7);
        do_long("mul_noise", OP_MULTU, 32'h00010000, 32'h00010000, 1'b1, 32'h0, 32'h1, 1'b0);
        do_long("mul_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h1, 32'hFFFFFFFE, 1'b0);
        do_long("div", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        do_long("div0", OP_DIVU, 32'd9, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd9, 1'b1);
        do_short("add_clr", OP_ADD, 32'd1, 32'd1, 32'd2);
        do_long("div_big", OP_DIVU, 32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0);
        do_short("add_pre", OP_ADD, 32'd1, 32'd1, 32'd2);

        go(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        repeat (9) tick();
        check("abort.busy_c10", 64'(busy), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("abort");
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        check("abort.no_done", 64'(dones), 64'h0);

        start = 1'b1;
        op    = OP_ADD;
        in1   = 32'd5;
        in2   = 32'd5;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_reset_vals("rst_prio");
        tick();
        check("rst_prio.later_done", 64'(done), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
